card_color_shuffler: RTL and testbench
======================================

Name: card_color_shuffler

Overview:
- Generates a random pair layout for a new round and writes it into the card memory.
- Sits directly upstream of the game state machine. It is driven by that machine's compute_colors_en and returns compute_done.
- Fills N slots with colour pairs taken from a fixed 12-entry palette, applies a Fisher-Yates shuffle driven by a free-running LFSR, then streams every card to the card memory as covered.

Parameters:
MAX_CARDS, 24, capacity of the card memory; always even, at most 32
ADDR_W, 5, card address width
COLOR_W, 12, RGB444 colour width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
num_of_cards  in  5  requested card count, sampled at start
compute_en  in  1  level request from the game state machine, held high while it waits
compute_done  out  1  high in DONE until compute_en drops
busy  out  1  high in FILL, SHUFFLE or WRITE
card_wr_en  out  1  one-cycle write strobe to the card memory
card_wr_address  out  ADDR_W  slot address being written
card_wr_color  out  COLOR_W  colour written to that slot
card_wr_state  out  2  always 2'b01 (covered) while card_wr_en=1; 2'b00 otherwise

Behaviour:
- Reset (rst=1 at a clock edge):
  - all outputs 0; FSM to IDLE; slot array cleared; LFSR loaded with 16'hACE1.
  - rst mid-operation aborts immediately; no further writes occur.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle outside reset, including in IDLE, so player timing seeds it. It never reaches 0.
- Count sampling (IDLE to FILL):
  - n = num_of_cards with bit0 forced to 0, then clamped to MAX_CARDS.
  - If n < 2: go straight to DONE with no writes.
- FILL:
  - One slot per cycle, i = 0..n-1.
  - slot[i] = palette[i>>1]: 12'hF00, 0F0, 00F, FF0, F0F, 0FF, F80, 8F0, 08F, F08, 888, FFF.
  - Exits after slot n-1. Duration: n cycles.
- SHUFFLE (Fisher-Yates, i from n-1 down to 1):
  - DRAW: candidate j = lfsr[4:0]. If j <= i, latch j and go to SWAP. Otherwise stay in DRAW; the LFSR advances for the next cycle.
  - SWAP: exchange slot[i] and slot[j] in one cycle (j == i is a legal no-op), then decrement i.
  - After the swap with i=1, go to WRITE.
  - No modulo hardware; the variable duration is expected.
- WRITE:
  - One write per cycle, k = 0..n-1: card_wr_en=1, card_wr_address=k, card_wr_color=slot[k], card_wr_state=2'b01.
  - Exactly n consecutive strobes, then DONE.
- DONE:
  - compute_done=1, held until compute_en=0, then back to IDLE. compute_done falls in the same cycle the FSM reaches IDLE.
  - A new start needs compute_en to be seen low then high; done stays high while en stays high.
- compute_en drops in FILL, SHUFFLE or WRITE: abort to IDLE next cycle. Writes already issued remain; compute_done is never raised.
- All outputs are registered (Moore). First strobe appears exactly n+S+1 cycles after compute_en is seen high, where S is the shuffle cycle count.
- Slot array: MAX_CARDS x COLOR_W flops. Slots at or above n are never written to the card memory.

Test Plan:
- rst, num_of_cards=16, compute_en=1 -> busy rises; exactly 16 strobes at addresses 0..15, all state 2'b01; each palette entry 0..7 appears exactly twice; compute_done=1 afterwards.
- Same run, then compute_en=0 -> compute_done=0 and busy=0 the next cycle. Raise en again -> a new layout that differs from the first, because the LFSR has advanced.
- num_of_cards=7 -> 6 strobes; num_of_cards=31 -> 24 strobes; num_of_cards=1 -> compute_done with zero strobes.
- compute_en dropped during SHUFFLE (n=24) -> no strobes, compute_done stays 0, FSM in IDLE; next request completes normally.
- rst asserted on the 5th WRITE strobe -> all outputs 0 next cycle, LFSR=16'hACE1; a following request with identical timing reproduces the same layout.
- Bench model: replay the LFSR from reset, compute the expected permutation, and compare every strobe's colour and address.

Source files
------------

// File: rtl/card_color_shuffler.sv
// card_color_shuffler: builds a shuffled pair layout for a new round and streams
// it into the card memory, with every card marked as covered.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   num_of_cards       requested card count, sampled when a request starts
//   compute_en         level request from the game FSM, held high while waiting
//   compute_done       high in DONE until compute_en drops
//   busy               high while filling, shuffling or writing
//   card_wr_en         one-cycle write strobe to the card memory
//   card_wr_address    slot address being written
//   card_wr_color      colour written to that slot
//   card_wr_state      2'b01 (covered) with each strobe, 2'b00 otherwise
module card_color_shuffler #(
    parameter int unsigned MAX_CARDS = 24,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned COLOR_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         num_of_cards,
    input  logic               compute_en,
    output logic               compute_done,
    output logic               busy,
    output logic               card_wr_en,
    output logic [ADDR_W-1:0]  card_wr_address,
    output logic [COLOR_W-1:0] card_wr_color,
    output logic [1:0]         card_wr_state
);

    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [11:0] PALETTE [12] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF,
        12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h888, 12'hFFF
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAW,
        S_SWAP,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [COLOR_W-1:0]  slot_q [MAX_CARDS];
    logic [COLOR_W-1:0]  slot_d [MAX_CARDS];

    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0]  wr_color_q, wr_color_d;
    logic [1:0]          wr_state_q, wr_state_d;

    logic [CNT_W-1:0]    n_req;
    logic [ADDR_W-1:0]   cand;
    logic                last_idx;

    // State, LFSR, slot array and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            n_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            for (int s = 0; s < int'(MAX_CARDS); s++) begin
                slot_q[s] <= '0;
            end
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_color_q <= '0;
            wr_state_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            n_q        <= n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            slot_q     <= slot_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_color_q <= wr_color_d;
            wr_state_q <= wr_state_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        n_d        = n_q;
        i_d        = i_q;
        j_d        = j_q;
        slot_d     = slot_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_color_d = '0;
        wr_state_d = 2'b00;

        // Even count, clamped to the memory size
        n_req = CNT_W'(num_of_cards & 5'b11110);
        if (n_req > CNT_W'(MAX_CARDS)) begin
            n_req = CNT_W'(MAX_CARDS);
        end
        cand     = ADDR_W'(lfsr_q[4:0]);
        last_idx = (CNT_W'(i_q) == (n_q - CNT_W'(1)));

        case (state_q)
            S_IDLE: begin
                if (compute_en) begin
                    n_d     = n_req;
                    i_d     = '0;
                    state_d = (n_req < CNT_W'(2)) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                slot_d[i_q] = COLOR_W'(PALETTE[4'(i_q >> 1)]);
                // i is left at n-1, which is where the shuffle starts
                if (last_idx) begin
                    state_d = S_DRAW;
                end else begin
                    i_d = i_q + ADDR_W'(1);
                end
            end
            S_DRAW: begin
                // Rejection sampling: out-of-range draws just wait for the next LFSR value
                if (cand <= i_q) begin
                    j_d     = cand;
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                slot_d[i_q] = slot_q[j_q];
                slot_d[j_q] = slot_q[i_q];
                if (i_q == ADDR_W'(1)) begin
                    i_d     = '0;
                    state_d = S_WRITE;
                end else begin
                    i_d     = i_q - ADDR_W'(1);
                    state_d = S_DRAW;
                end
            end
            S_WRITE: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = i_q;
                wr_color_d = slot_q[i_q];
                wr_state_d = 2'b01;
                if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    i_d = i_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                if (!compute_en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Request withdrawn while working: abandon the round without another write
        if (!compute_en && (state_q == S_FILL || state_q == S_DRAW ||
                            state_q == S_SWAP || state_q == S_WRITE)) begin
            state_d    = S_IDLE;
            wr_en_d    = 1'b0;
            wr_addr_d  = '0;
            wr_color_d = '0;
            wr_state_d = 2'b00;
        end

        busy_d = (state_d == S_FILL) || (state_d == S_DRAW) ||
                 (state_d == S_SWAP) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    assign compute_done    = done_q;
    assign busy            = busy_q;
    assign card_wr_en      = wr_en_q;
    assign card_wr_address = wr_addr_q;
    assign card_wr_color   = wr_color_q;
    assign card_wr_state   = wr_state_q;

endmodule

// File: tb/tb_card_color_shuffler.sv
// Self-checking bench for card_color_shuffler: a cycle-level reference model
// built from the round's rules (LFSR replay + Fisher-Yates with rejection)
// is compared against the DUT outputs every cycle, plus directed scenarios.
module tb_card_color_shuffler;

    localparam int unsigned MAX_CARDS = 24;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned COLOR_W   = 12;

    localparam logic [11:0] PAL [12] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF,
        12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h888, 12'hFFF
    };

    logic               clk;
    logic               rst;
    logic [4:0]         num_of_cards;
    logic               compute_en;
    logic               compute_done;
    logic               busy;
    logic               card_wr_en;
    logic [ADDR_W-1:0]  card_wr_address;
    logic [COLOR_W-1:0] card_wr_color;
    logic [1:0]         card_wr_state;

    card_color_shuffler #(
        .MAX_CARDS(MAX_CARDS),
        .ADDR_W   (ADDR_W),
        .COLOR_W  (COLOR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .num_of_cards   (num_of_cards),
        .compute_en     (compute_en),
        .compute_done   (compute_done),
        .busy           (busy),
        .card_wr_en     (card_wr_en),
        .card_wr_address(card_wr_address),
        .card_wr_color  (card_wr_color),
        .card_wr_state  (card_wr_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] lfsr_m;
    bit          m_run;
    int          m_o, m_n, m_s;
    logic [11:0] exp_layout [32];
    logic        e_busy, e_done, e_wr;
    logic [4:0]  e_addr;
    logic [11:0] e_color;
    logic [1:0]  e_state;

    // Layout and shuffle length for a request starting with LFSR value 'pre'
    task automatic build(input logic [15:0] pre);
        logic [15:0] v;
        logic [11:0] t;
        int n, j, guard;
        n = int'(num_of_cards) & ~1;
        if (n > int'(MAX_CARDS)) n = int'(MAX_CARDS);
        v = pre;
        repeat (n + 1) v = lstep(v);
        for (int i = 0; i < n; i++) exp_layout[i] = PAL[i / 2];
        m_s = 0;
        for (int i = n - 1; i >= 1; i--) begin
            guard = 0;
            while (int'(v[4:0]) > i && guard < 100000) begin
                v = lstep(v);
                m_s++;
                guard++;
            end
            j = int'(v[4:0]);
            v = lstep(lstep(v));
            m_s += 2;
            t = exp_layout[i];
            exp_layout[i] = exp_layout[j];
            exp_layout[j] = t;
        end
        m_n = n;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            lfsr_m = 16'hACE1;
            m_run  = 1'b0;
            m_o    = 0;
        end else begin
            if (m_run) begin
                if (!compute_en) m_run = 1'b0;
                else m_o++;
            end else if (compute_en) begin
                build(lfsr_m);
                m_run = 1'b1;
                m_o   = 1;
            end
            lfsr_m = lstep(lfsr_m);
        end
        e_busy = 1'b0; e_done = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_color = '0; e_state = 2'b00;
        if (m_run) begin
            e_busy = (m_o <= 2 * m_n + m_s);
            e_done = (m_o >= 2 * m_n + m_s + 1);
            e_wr   = (m_o >= m_n + m_s + 2) && (m_o <= 2 * m_n + m_s + 1);
            if (e_wr) begin
                e_addr  = 5'(m_o - (m_n + m_s + 2));
                e_color = exp_layout[e_addr];
                e_state = 2'b01;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",     32'(busy),            32'(e_busy));
            chk("done",     32'(compute_done),    32'(e_done));
            chk("wr_en",    32'(card_wr_en),      32'(e_wr));
            chk("wr_addr",  32'(card_wr_address), 32'(e_addr));
            chk("wr_color", 32'(card_wr_color),   32'(e_color));
            chk("wr_state", 32'(card_wr_state),   32'(e_state));
            chk("lfsr",     32'(dut.lfsr_q),      32'(lfsr_m));
        end
    end

    // ---------------- directed scenarios ----------------
    logic [11:0] obs_color [32];
    int          obs_cnt;
    logic [11:0] la [32];
    logic [11:0] lb [32];

    task automatic do_reset();
        rst = 1'b1;
        compute_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        chk("rst_outs", 32'({busy, compute_done, card_wr_en, card_wr_state}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("lfsr_step1", 32'(dut.lfsr_q), 32'h0000E270);
        @(negedge clk);
        chk("lfsr_step2", 32'(dut.lfsr_q), 32'h00007138);
    endtask

    task automatic run(input logic [4:0] req, input int exp_cnt);
        int cyc;
        obs_cnt = 0;
        cyc = 0;
        num_of_cards = req;
        compute_en = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (card_wr_en) begin
                if (obs_cnt < 32) begin
                    chk("strobe_addr", 32'(card_wr_address), 32'(obs_cnt));
                    chk("strobe_state", 32'(card_wr_state), 32'h1);
                    obs_color[obs_cnt] = card_wr_color;
                end
                obs_cnt++;
            end
        end while (!compute_done && cyc < 3000);
        chk("done_reached", 32'(compute_done), 32'h1);
        chk("strobe_count", 32'(obs_cnt), 32'(exp_cnt));
    endtask

    task automatic release_en();
        compute_en = 1'b0;
        @(negedge clk);
        chk("release_done", 32'(compute_done), 32'h0);
        chk("release_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        int cnt, diff, cyc;
        rst = 1'b1;
        compute_en = 1'b0;
        num_of_cards = '0;
        @(negedge clk);
        chk_on = 1'b1;

        // 16 cards: each of the first 8 palette colours exactly twice
        do_reset();
        run(5'd16, 16);
        la = obs_color;
        for (int p = 0; p < 8; p++) begin
            cnt = 0;
            for (int k = 0; k < 16; k++) if (la[k] == PAL[p]) cnt++;
            chk("pal_pair", 32'(cnt), 32'h2);
        end
        release_en();

        // Second round: LFSR has moved on, so the layout changes
        run(5'd16, 16);
        lb = obs_color;
        diff = 0;
        for (int k = 0; k < 16; k++) if (la[k] != lb[k]) diff++;
        chk("layout_changed", 32'(diff != 0), 32'h1);
        release_en();

        // Count normalisation: odd rounds down, large clamps, tiny finishes immediately
        run(5'd7, 6);
        release_en();
        run(5'd31, 24);
        release_en();
        run(5'd1, 0);
        release_en();

        // Withdraw the request in the middle of the shuffle
        num_of_cards = 5'd24;
        compute_en = 1'b1;
        obs_cnt = 0;
        repeat (27) begin
            @(negedge clk);
            if (card_wr_en) obs_cnt++;
        end
        chk("abort_busy_before", 32'(busy), 32'h1);
        compute_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (card_wr_en) obs_cnt++;
            chk("abort_no_done", 32'(compute_done), 32'h0);
        end
        chk("abort_strobes", 32'(obs_cnt), 32'h0);
        chk("abort_busy_after", 32'(busy), 32'h0);
        run(5'd24, 24);
        release_en();

        // Reset on the 5th strobe, then replay the first round's timing
        do_reset();
        num_of_cards = 5'd16;
        compute_en = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 5 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (card_wr_en) cnt++;
        end
        chk("rst_strobe_seen", 32'(cnt), 32'h5);
        rst = 1'b1;
        compute_en = 1'b0;
        @(negedge clk);
        chk("midrst_outs", 32'({busy, compute_done, card_wr_en, card_wr_state}), 32'h0);
        chk("midrst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        do_reset();
        run(5'd16, 16);
        for (int k = 0; k < 16; k++) chk("replay_layout", 32'(obs_color[k]), 32'(la[k]));
        release_en();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
